// File: rtl/gen3_descrambler_16.sv
// gen3_descrambler_16
// 16-bit Gen3 receive descrambler with 128b/130b block tracking.
// The Galois LFSR (x^23+x^21+x^16+x^8+x^5+x^2+1) advances 16 steps per
// scrambled word. Keystream bit k is taken from the MSB before step k.
// Optional: define GEN3_DESCR_ERR_CNT_EN to add a saturating sync-error counter.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no block alignment; words dropped until block_start
// ST_DATA  | data block; every byte descrambled, LFSR advances
// ST_OS    | ordered set; byte 0 of word 0 raw, rest descrambled
// ST_SKP   | SKP block (or bad header); pass-through, LFSR held
// ST_EIEOS | EIEOS; pass-through, LFSR held, reloaded from seed after word 7
module gen3_descrambler_16 (
    input  logic        pclk,
    input  logic        reset_n,
    input  logic [23:0] seedValue,
    input  logic [15:0] data_in,
    input  logic        data_in_valid,
    input  logic        block_start,
    input  logic [1:0]  sync_header,
    output logic [15:0] data_out,
    output logic        data_out_valid,
    output logic [1:0]  block_type,
`ifdef GEN3_DESCR_ERR_CNT_EN
    output logic [7:0]  err_cnt,
`endif
    output logic        sync_err
);

    typedef enum logic [2:0] {ST_IDLE, ST_DATA, ST_OS, ST_SKP, ST_EIEOS} state_t;

    localparam logic [22:0] LFSR_TAPS = 23'h210125;
    localparam logic [1:0]  BT_DATA   = 2'd0;
    localparam logic [1:0]  BT_OS     = 2'd1;
    localparam logic [1:0]  BT_SKP    = 2'd2;
    localparam logic [1:0]  BT_EIEOS  = 2'd3;

    state_t      r_state, w_state_nxt, w_mode;
    logic [22:0] r_lfsr, w_lfsr_nxt, w_lfsr_adv, w_lfsr_tmp;
    logic [15:0] w_ks, w_dout;
    logic [2:0]  r_cnt, w_cnt_nxt, w_idx;
    logic [1:0]  r_type, w_type_nxt;
    logic        w_emit, w_err;
    logic        w_unused_seed_msb;

    assign w_unused_seed_msb = seedValue[23];

    // Keystream for one word and the LFSR value 16 steps ahead
    always_comb begin
        w_lfsr_tmp = r_lfsr;
        w_ks       = '0;
        for (int k = 0; k < 16; k++) begin
            w_ks[k]    = w_lfsr_tmp[22];
            w_lfsr_tmp = {w_lfsr_tmp[21:0], 1'b0} ^ (w_lfsr_tmp[22] ? LFSR_TAPS : 23'h0);
        end
        w_lfsr_adv = w_lfsr_tmp;
    end

    // Next state, block decode, descrambled word and error detection
    always_comb begin
        w_state_nxt = r_state;
        w_mode      = r_state;
        w_cnt_nxt   = r_cnt;
        w_idx       = r_cnt;
        w_type_nxt  = r_type;
        w_lfsr_nxt  = r_lfsr;
        w_dout      = data_in;
        w_emit      = 1'b0;
        w_err       = 1'b0;
        if (data_in_valid) begin
            if (block_start) begin
                w_err  = (r_cnt != 3'd0);
                w_idx  = 3'd0;
                w_emit = 1'b1;
                case (sync_header)
                    2'b10: begin
                        w_mode     = ST_DATA;
                        w_type_nxt = BT_DATA;
                    end
                    2'b01: begin
                        if (data_in[7:0] == 8'hAA) begin
                            w_mode     = ST_SKP;
                            w_type_nxt = BT_SKP;
                        end else if (data_in[7:0] == 8'h00) begin
                            w_mode     = ST_EIEOS;
                            w_type_nxt = BT_EIEOS;
                        end else begin
                            w_mode     = ST_OS;
                            w_type_nxt = BT_OS;
                        end
                    end
                    default: begin
                        // Bad header behaves like SKP (raw, LFSR held) but reports as data
                        w_mode     = ST_SKP;
                        w_type_nxt = BT_DATA;
                        w_err      = 1'b1;
                    end
                endcase
                w_state_nxt = w_mode;
                w_cnt_nxt   = 3'd1;
            end else if (r_state != ST_IDLE) begin
                if (r_cnt == 3'd0) begin
                    // Expected a block boundary; lose alignment and drop the word
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_emit    = 1'b1;
                    w_cnt_nxt = r_cnt + 3'd1;
                end
            end
            if (w_emit) begin
                case (w_mode)
                    ST_DATA: begin
                        w_dout     = data_in ^ w_ks;
                        w_lfsr_nxt = w_lfsr_adv;
                    end
                    ST_OS: begin
                        w_dout = data_in ^ w_ks;
                        if (w_idx == 3'd0) w_dout[7:0] = data_in[7:0];
                        w_lfsr_nxt = w_lfsr_adv;
                    end
                    ST_EIEOS: begin
                        if (w_idx == 3'd7) w_lfsr_nxt = seedValue[22:0];
                    end
                    default: ;
                endcase
            end
        end
    end

    // FSM state, word counter, block type and LFSR registers
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 3'd0;
            r_type  <= BT_DATA;
            r_lfsr  <= seedValue[22:0];
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_type  <= w_type_nxt;
            r_lfsr  <= w_lfsr_nxt;
        end
    end

    // Registered outputs, one cycle behind the input word
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            data_out       <= 16'h0000;
            data_out_valid <= 1'b0;
            block_type     <= BT_DATA;
            sync_err       <= 1'b0;
        end else begin
            data_out_valid <= w_emit;
            sync_err       <= w_err;
            if (w_emit) begin
                data_out   <= w_dout;
                block_type <= w_type_nxt;
            end
        end
    end

`ifdef GEN3_DESCR_ERR_CNT_EN
    // Saturating count of sync errors, updated alongside the sync_err pulse
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            err_cnt <= 8'h00;
        end else if (w_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_gen3_descrambler_16.sv
// Bench for gen3_descrambler_16. A transmit-side scrambler model (LFSR as
// multiplication by x modulo the generator polynomial) scrambles random
// plaintext; the descrambler output must reproduce the plaintext.
module tb_gen3_descrambler_16;

    localparam int K_DATA  = 0;
    localparam int K_OS    = 1;
    localparam int K_SKP   = 2;
    localparam int K_EIE   = 3;
    localparam int K_BAD   = 4;

    logic        pclk = 1'b0;
    logic        reset_n;
    logic [23:0] seedValue;
    logic [15:0] data_in;
    logic        data_in_valid;
    logic        block_start;
    logic [1:0]  sync_header;
    logic [15:0] data_out;
    logic        data_out_valid;
    logic [1:0]  block_type;
    logic        sync_err;
`ifdef GEN3_DESCR_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;
    logic [22:0] tx_lfsr;

    gen3_descrambler_16 dut (
        .pclk           (pclk),
        .reset_n        (reset_n),
        .seedValue      (seedValue),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .block_start    (block_start),
        .sync_header    (sync_header),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .block_type     (block_type),
`ifdef GEN3_DESCR_ERR_CNT_EN
        .err_cnt        (err_cnt),
`endif
        .sync_err       (sync_err)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Transmit keystream: state is a polynomial, each step multiplies by x mod P
    task automatic next_ks(output logic [15:0] ks);
        logic [23:0] s;
        s = {1'b0, tx_lfsr};
        for (int k = 0; k < 16; k++) begin
            s     = s << 1;
            ks[k] = s[23];
            if (s[23]) s = s ^ 24'hA10125;
        end
        tx_lfsr = s[22:0];
    endtask

    // Drive one cycle, then check the registered outputs just after the edge
    task automatic cycle(input logic [15:0] din, input logic v, input logic bs,
                         input logic [1:0] hdr, input logic ev, input logic [15:0] ed,
                         input logic [1:0] et, input logic ee);
        data_in       = din;
        data_in_valid = v;
        block_start   = bs;
        sync_header   = hdr;
        @(posedge pclk);
        #1;
        check("out_valid", {31'b0, data_out_valid}, {31'b0, ev});
        if (ev) begin
            check("data_out", {16'b0, data_out}, {16'b0, ed});
            check("block_type", {30'b0, block_type}, {30'b0, et});
        end
        check("sync_err", {31'b0, sync_err}, {31'b0, ee});
        data_in_valid = 1'b0;
        block_start   = 1'b0;
    endtask

    task automatic send_block(input int kind, input int nwords, input int gap, input bit misal);
        logic [15:0] pt, din, ks;
        logic [1:0]  hdr, et;
        for (int i = 0; i < nwords; i++) begin
            pt  = 16'($urandom);
            hdr = 2'b01;
            et  = 2'd0;
            case (kind)
                K_DATA: hdr = 2'b10;
                K_OS: begin
                    et = 2'd1;
                    if (i == 0) pt[7:0] = 8'h10 + 8'($urandom_range(0, 127));
                end
                K_SKP: begin
                    et = 2'd2;
                    if (i == 0) pt[7:0] = 8'hAA;
                end
                K_EIE: begin
                    et = 2'd3;
                    if (i == 0) pt[7:0] = 8'h00;
                end
                default: hdr = ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
            endcase
            din = pt;
            if (kind == K_DATA || kind == K_OS) begin
                next_ks(ks);
                din = pt ^ ks;
                if (kind == K_OS && i == 0) din[7:0] = pt[7:0];
            end
            cycle(din, 1'b1, i == 0, hdr, 1'b1, pt, et, (i == 0) && (misal || kind == K_BAD));
            for (int g = 0; g < gap; g++)
                cycle(16'($urandom), 1'b0, 1'b0, 2'($urandom), 1'b0, 16'h0, 2'd0, 1'b0);
        end
        if (kind == K_EIE && nwords == 8) tx_lfsr = seedValue[22:0];
    endtask

    initial begin
        reset_n       = 1'b0;
        seedValue     = 24'h1DBFBC;
        data_in       = 16'h0;
        data_in_valid = 1'b0;
        block_start   = 1'b0;
        sync_header   = 2'b00;
        tx_lfsr       = seedValue[22:0];
        #1;
        check("rst_data_out", {16'b0, data_out}, 32'h0);
        check("rst_valid", {31'b0, data_out_valid}, 32'h0);
        check("rst_type", {30'b0, block_type}, 32'h0);
        check("rst_sync_err", {31'b0, sync_err}, 32'h0);
        @(posedge pclk);
        @(posedge pclk);
        #1;
        reset_n = 1'b1;

        // Words before any block_start are dropped silently
        cycle(16'h1234, 1'b1, 1'b0, 2'b10, 1'b0, 16'h0, 2'd0, 1'b0);
        cycle(16'h5678, 1'b1, 1'b0, 2'b01, 1'b0, 16'h0, 2'd0, 1'b0);

        send_block(K_DATA, 8, 0, 1'b0);
        send_block(K_SKP,  8, 0, 1'b0);
        send_block(K_DATA, 8, 0, 1'b0);
        send_block(K_OS,   8, 0, 1'b0);
        send_block(K_DATA, 8, 0, 1'b0);

        send_block(K_EIE,  8, 0, 1'b0);
        check("lfsr_after_eieos", {9'b0, dut.r_lfsr}, {9'b0, seedValue[22:0]});
        send_block(K_DATA, 8, 0, 1'b0);

        // block_start arriving at word 4
        send_block(K_DATA, 4, 0, 1'b0);
        send_block(K_DATA, 8, 0, 1'b1);
`ifdef GEN3_DESCR_ERR_CNT_EN
        check("err_cnt_one", {24'b0, err_cnt}, 32'h1);
`endif

        // Valid only one cycle in three
        send_block(K_DATA, 8, 2, 1'b0);

        // Missing block_start at a block boundary: error, then IDLE drops
        cycle(16'hBEEF, 1'b1, 1'b0, 2'b10, 1'b0, 16'h0, 2'd0, 1'b1);
        cycle(16'hCAFE, 1'b1, 1'b0, 2'b10, 1'b0, 16'h0, 2'd0, 1'b0);
        send_block(K_DATA, 8, 0, 1'b0);

        // Asynchronous reset in the middle of a block
        send_block(K_DATA, 3, 0, 1'b0);
        seedValue = {1'b1, 23'($urandom)};
        reset_n   = 1'b0;
        #2;
        check("mid_rst_data_out", {16'b0, data_out}, 32'h0);
        check("mid_rst_valid", {31'b0, data_out_valid}, 32'h0);
        check("mid_rst_type", {30'b0, block_type}, 32'h0);
`ifdef GEN3_DESCR_ERR_CNT_EN
        check("mid_rst_err_cnt", {24'b0, err_cnt}, 32'h0);
`endif
        @(posedge pclk);
        #1;
        reset_n = 1'b1;
        tx_lfsr = seedValue[22:0];
        cycle(16'hA5A5, 1'b1, 1'b0, 2'b10, 1'b0, 16'h0, 2'd0, 1'b0);
        send_block(K_DATA, 8, 0, 1'b0);

        // Invalid headers: raw pass-through, LFSR held
        send_block(K_BAD, 8, 0, 1'b0);
        for (int n = 0; n < 300; n++) send_block(K_BAD, 1, 0, 1'b1);
`ifdef GEN3_DESCR_ERR_CNT_EN
        check("err_cnt_sat", {24'b0, err_cnt}, 32'hFF);
`endif
        send_block(K_DATA, 8, 0, 1'b1);
        send_block(K_OS,   8, 0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
